tape_buf_arb: RTL and testbench
===============================

# tape_buf_arb

Memory-port scheduler for the tape buffer. It shares one byte-wide request/acknowledge memory port between two requesters: the download writer, which fills the buffer from `ioctl`, and the tape player's read port (`rd_en`/`rd`/`addr`/`din`). It produces the `rd_en` slot strobe that the tape player's read handshake depends on, and it reports the downloaded image size to `smart_tape`. It sits between `smart_tape` and the SDRAM/BRAM controller.

## Interface

**Parameters**
- `AW`, default 25: memory address width.
- `BASE`, default 0: buffer base address added to every memory address.
- `GAP`, default 2: number of cycles `buff_rd_en` stays low after each completed read. Legal range is 2 to 15.

**Ports**
- `clk_sys` in 1: system clock. This is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `ioctl_download` in 1: high while an image is being downloaded.
- `ioctl_wr` in 1: one-cycle write strobe.
- `ioctl_addr` in 25: write byte offset.
- `ioctl_dout` in 8: write data.
- `ioctl_wait` out 1: write back-pressure.
- `tape_size` out 25: highest written offset + 1 for the current download.
- `buff_rd_en` out 1: read slot strobe to the tape player.
- `buff_rd` in 1: read request from the tape player. It is only meaningful while `buff_rd_en` is high.
- `buff_addr` in 25: read byte offset.
- `buff_din` out 8: read data to the tape player.
- `mem_req` out 1: memory request. It is held high until acknowledged.
- `mem_we` out 1: 1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr` out AW: `BASE` + offset.
- `mem_din` out 8: write data.
- `mem_dout` in 8: read data. Valid in the `mem_ack` cycle.
- `mem_ack` in 1: one-cycle acknowledge.

## Operation

- **Write buffer.** Writes go into a one-deep buffer (`wpend`, `waddr`, `wdata`).
  - `ioctl_wr` with `wpend` = 0 loads the buffer and sets `wpend`.
  - `ioctl_wr` with `wpend` = 1 is a protocol violation; the write is dropped.
  - `ioctl_wait` = `wpend`.
- **Size tracking.**
  - The rising edge of `ioctl_download` clears `tape_size` to 0.
  - Each accepted write sets `tape_size` to max(`tape_size`, `ioctl_addr` + 1), computed in 25-bit arithmetic. An offset of 0x1FFFFFF wraps to 0 and is ignored.
- **States.** The FSM has four states: IDLE, WRITE, READ, GAP.
- **IDLE.**
  - Write has priority over read. If `wpend` = 1, the block drives `mem_req`=1, `mem_we`=1, `mem_addr`=`BASE`+`waddr`, `mem_din`=`wdata`, then goes to WRITE.
  - Otherwise, if `buff_rd_en` & `buff_rd` & ~`ioctl_download`, it latches `buff_addr`, drives `mem_req`=1, `mem_we`=0, then goes to READ. `buff_rd_en` stays high through READ.
- **WRITE.**
  - On `mem_ack`: `mem_req` goes to 0, `wpend` goes to 0, and the FSM returns to IDLE.
- **READ.**
  - On `mem_ack`, in the same edge: `buff_din` <= `mem_dout`, `mem_req` goes to 0, `buff_rd_en` goes to 0, and the gap counter loads `GAP`-1. The FSM goes to GAP.
  - The tape player captures `din` in the first cycle `rd_en` is low. `buff_din` is therefore valid exactly when `buff_rd_en` falls.
- **GAP.**
  - `buff_rd_en` stays low. The counter decrements each cycle.
  - At 0 the FSM returns to IDLE. `buff_rd_en` rises in the same edge unless `ioctl_download` is high.
  - A pending write may not start during GAP. It waits for IDLE.
- **`buff_rd_en` outside READ/GAP.** It is high in IDLE whenever `ioctl_download` = 0.
  - While `ioctl_download` = 1 it is forced low in IDLE, so the tape player sees no slots.
  - An active READ is allowed to complete.
- **Data holding.** `buff_din` holds its value until the next read completes.
- **Reset.** Reset takes the FSM to IDLE from any state, including mid-transaction. Reset values:
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
  - `wpend`=0, so `ioctl_wait`=0.
  - `tape_size`=0, `buff_din`=0x00.
  - `buff_rd_en`=0. It rises on the first cycle after reset is released, provided `ioctl_download`=0.
  - Any outstanding memory transaction is abandoned. The memory controller must tolerate `mem_req` dropping.

## Timing

- **Outputs.** All outputs are registered. There are no combinational paths from inputs to outputs.
- **Read latency.** `buff_rd` is sampled high at edge N. Then:
  - `mem_req` rises at edge N+1.
  - If `mem_ack` arrives at edge M, `buff_din` is valid and `buff_rd_en` is low from edge M+1.
  - `buff_rd_en` is high again at edge M+1+`GAP`.
- **Write latency.** `ioctl_wr` at edge N gives `mem_req` at N+2 when the FSM is idle.
- **Simultaneous events.** When `wpend` and `buff_rd` are both present in IDLE, the write wins. `buff_rd_en` stays high, and the read is served after the write acks.
- **Same-edge write strobe.** An `ioctl_wr` in the same edge that `mem_ack` clears `wpend` is accepted; the new write wins.
- **`mem_ack` outside WRITE/READ** is ignored.

## Test plan

1. **Reset/idle.** Hold `reset` 3 cycles, then release with `ioctl_download`=0 -> all outputs 0 during reset, and `buff_rd_en`=1 one cycle after release.
2. **Download.** Pulse `ioctl_download`, with writes at offsets 0..9 (data 0xA0+i) every 4 cycles, memory acking 2 cycles after each `mem_req` -> 10 writes with `mem_addr`=`BASE`+i, `tape_size`=10, `buff_rd_en`=0 throughout. Then write offset 3 again -> `tape_size` stays 10.
3. **Tape read.** `ioctl_download`=0, `buff_rd`=1 with `buff_addr`=5, `mem_dout`=0xA5 acked after 3 cycles -> `buff_rd_en` falls on the same edge `buff_din` becomes 0xA5, stays low for `GAP`=2 cycles, then rises again.
4. **Collision.** A write is pending and `buff_rd` is asserted in the same cycle -> the write is issued first and the read follows after its ack. `buff_rd_en` stays high until the read ack.
5. **Back-pressure.** A second `ioctl_wr` arrives while the memory withholds ack -> `ioctl_wait`=1, the second write is dropped, and `tape_size` reflects only the first.
6. **Mid-read reset.** Assert `reset` in READ before `mem_ack` -> `mem_req`=0 on the next edge, the FSM goes to IDLE, and a stale `mem_ack` after release leaves `buff_din` at 0x00.

Source files
------------

// File: rtl/tape_buf_arb_if.sv
// Byte-wide request/acknowledge memory port used by the tape buffer arbiter.
// The arbiter is the master; the SDRAM/BRAM controller is the slave.
interface tape_buf_arb_if #(
  parameter int AW = 25
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_din,
    input  mem_dout, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_din,
    output mem_dout, mem_ack
  );
endinterface

// File: rtl/tape_buf_arb.sv
// Tape buffer memory-port scheduler: a one-deep download write buffer and the
// tape player's slotted read port share one req/ack byte-wide memory port.
//
// state   | meaning
// S_IDLE  | port free; buffered write first, then a tape read
// S_WRITE | buffered write in flight
// S_READ  | tape read in flight, buff_rd_en held high
// S_GAP   | buff_rd_en low for GAP cycles after a read
module tape_buf_arb #(
  parameter int AW   = 25,
  parameter int BASE = 0,
  parameter int GAP  = 2
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           ioctl_download,
  input  logic           ioctl_wr,
  input  logic [24:0]    ioctl_addr,
  input  logic [7:0]     ioctl_dout,
  output logic           ioctl_wait,
  output logic [24:0]    tape_size,
  output logic           buff_rd_en,
  input  logic           buff_rd,
  input  logic [24:0]    buff_addr,
  output logic [7:0]     buff_din,
  tape_buf_arb_if.master mem
);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_GAP} state_t;

  localparam logic [AW-1:0] BASE_A   = AW'(BASE);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP - 1);

  state_t        state_q, state_n;
  logic          req_q, req_n;
  logic          we_q, we_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [7:0]    wdin_q, wdin_n;
  logic          rd_en_q, rd_en_n;
  logic [7:0]    din_q, din_n;
  logic [3:0]    gap_q, gap_n;

  logic          wpend;
  logic [24:0]   waddr;
  logic [7:0]    wdata;
  logic          dl_q;
  logic          wr_done;
  logic          wr_accept;
  logic [24:0]   size_base;
  logic [24:0]   size_cand;

  // A strobe landing on the edge that retires the buffered write is accepted.
  assign wr_done   = (state_q == S_WRITE) && mem.mem_ack;
  assign wr_accept = ioctl_wr && (!wpend || wr_done);
  assign size_base = (ioctl_download && !dl_q) ? 25'd0 : tape_size;
  assign size_cand = ioctl_addr + 25'd1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wpend     <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      dl_q      <= 1'b0;
      tape_size <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (wr_accept) begin
        wpend <= 1'b1;
        waddr <= ioctl_addr;
        wdata <= ioctl_dout;
      end else if (wr_done) begin
        wpend <= 1'b0;
      end
      // size_cand of 0 means the offset wrapped and carries no size information
      if (wr_accept && (size_cand != 25'd0) && (size_cand > size_base))
        tape_size <= size_cand;
      else
        tape_size <= size_base;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdin_q  <= '0;
      rd_en_q <= 1'b0;
      din_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdin_q  <= wdin_n;
      rd_en_q <= rd_en_n;
      din_q   <= din_n;
      gap_q   <= gap_n;
    end
  end

  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    we_n    = we_q;
    addr_n  = addr_q;
    wdin_n  = wdin_q;
    rd_en_n = rd_en_q;
    din_n   = din_q;
    gap_n   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        rd_en_n = !ioctl_download;
        if (wpend) begin
          req_n   = 1'b1;
          we_n    = 1'b1;
          addr_n  = BASE_A + AW'(waddr);
          wdin_n  = wdata;
          state_n = S_WRITE;
        end else if (rd_en_q && buff_rd && !ioctl_download) begin
          req_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = BASE_A + AW'(buff_addr);
          state_n = S_READ;
        end
      end
      S_WRITE: begin
        rd_en_n = !ioctl_download;
        if (mem.mem_ack) begin
          req_n   = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_READ: begin
        if (mem.mem_ack) begin
          din_n   = mem.mem_dout;
          req_n   = 1'b0;
          rd_en_n = 1'b0;
          gap_n   = GAP_LOAD;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          rd_en_n = !ioctl_download;
          state_n = S_IDLE;
        end else begin
          gap_n = gap_q - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_we   = we_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_din  = wdin_q;
  assign ioctl_wait   = wpend;
  assign buff_rd_en   = rd_en_q;
  assign buff_din     = din_q;
endmodule

// File: tb/tb_tape_buf_arb.sv
// Bench for tape_buf_arb: a latency-programmable memory responder, a download
// vector table, hand-built corner sequences and a randomized read/write mix.
module tb_tape_buf_arb;
  localparam int          AW     = 25;
  localparam int          BASE_P = 'h40;
  localparam int          GAP_P  = 2;
  localparam logic [24:0] BASE_V = 25'h40;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [24:0] tape_size;
  logic        buff_rd_en;
  logic        buff_rd;
  logic [24:0] buff_addr;
  logic [7:0]  buff_din;

  tape_buf_arb_if #(.AW(AW)) bus ();

  tape_buf_arb #(.AW(AW), .BASE(BASE_P), .GAP(GAP_P)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .tape_size      (tape_size),
    .buff_rd_en     (buff_rd_en),
    .buff_rd        (buff_rd),
    .buff_addr      (buff_addr),
    .buff_din       (buff_din),
    .mem            (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_rec_t;

  typedef struct {
    logic [24:0] off;
    logic [7:0]  data;
    logic [24:0] exp_size;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [24:0] size_m;
  logic [7:0]  mem_arr [0:255];
  logic [7:0]  shadow  [0:255];
  wr_rec_t     wr_log[$];
  wr_rec_t     exp_wr[$];
  vec_t        vecs[$];
  int          ack_lat   = 2;
  bit          ack_en    = 1'b1;
  bit          stale_ack = 1'b0;
  int          lat_cnt   = 0;
  logic [7:0]  ridx;

  // memory model: acks after ack_lat idle cycles, stores writes, serves reads
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i) ^ 8'h5A;
    bus.mem_ack  = 1'b0;
    bus.mem_dout = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      bus.mem_ack = 1'b0;
      if (stale_ack) begin
        bus.mem_ack  = 1'b1;
        bus.mem_dout = 8'hEE;
        stale_ack    = 1'b0;
        lat_cnt      = 0;
      end else if (bus.mem_req && ack_en) begin
        if (lat_cnt >= ack_lat) begin
          ridx        = 8'(bus.mem_addr - BASE_V);
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            mem_arr[ridx] = bus.mem_din;
            wr_log.push_back('{bus.mem_addr, bus.mem_din});
          end else begin
            bus.mem_dout = mem_arr[ridx];
          end
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    wr_rec_t g;
    wr_rec_t e;
    @(posedge clk_sys);
    #2;
    while (wr_log.size() > 0) begin
      g = wr_log.pop_front();
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required none", g.addr, g.data);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", g.addr, e.addr);
        chk("wr_data", g.data, e.data);
      end
    end
    chk("tape_size", tape_size, size_m);
    ioctl_wr = 1'b0;
  endtask

  task automatic set_dl(input logic v);
    if (v && !ioctl_download) size_m = 25'd0;
    ioctl_download = v;
  endtask

  task automatic drive_wr(input logic [24:0] off, input logic [7:0] d);
    logic [24:0] s;
    logic [24:0] a;
    ioctl_wr   = 1'b1;
    ioctl_addr = off;
    ioctl_dout = d;
    if (!ioctl_wait || (bus.mem_ack && bus.mem_req && bus.mem_we)) begin
      a = off + BASE_V;
      exp_wr.push_back('{a, d});
      shadow[8'(off)] = d;
      s = off + 25'd1;
      if (s != 25'd0 && s > size_m) size_m = s;
    end
  endtask

  task automatic wait_wr_free();
    int n = 0;
    while (ioctl_wait && n < 40) begin step(); n++; end
    total++;
    if (ioctl_wait) begin
      bad++;
      $display("FAIL wr_free: ioctl_wait got 1 required 0 after timeout");
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.mem_req && n < 40) begin step(); n++; end
    total++;
    if (!bus.mem_req) begin
      bad++;
      $display("FAIL %s: mem_req got 0 required 1 after timeout", name);
    end
  endtask

  task automatic wait_read_issue(input string name);
    int n = 0;
    while (!(bus.mem_req && !bus.mem_we) && n < 40) begin step(); n++; end
    total++;
    if (!(bus.mem_req && !bus.mem_we)) begin
      bad++;
      $display("FAIL %s: read request got none required one after timeout", name);
    end
  endtask

  task automatic finish_read(input string name, input logic [7:0] exp_d);
    int   n = 0;
    int   g = 0;
    logic ack_prev = 1'b0;
    while (buff_rd_en && n < 60) begin
      ack_prev = bus.mem_ack;
      step();
      n++;
    end
    total++;
    if (buff_rd_en) begin
      bad++;
      $display("FAIL %s_fall: buff_rd_en got 1 required 0 after timeout", name);
    end else begin
      chk({name, "_din"}, buff_din, exp_d);
      chk({name, "_ack_edge"}, ack_prev, 1);
      chk({name, "_req_drop"}, bus.mem_req, 0);
      while (!buff_rd_en && g < 40) begin step(); g++; end
      chk({name, "_gap_len"}, g, GAP_P);
    end
  endtask

  initial begin
    int          n;
    logic [24:0] ea;
    logic [24:0] ra;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    buff_rd        = 1'b0;
    buff_addr      = '0;
    size_m         = '0;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;

    for (int i = 0; i < 10; i++) vecs.push_back('{25'(i), 8'hA0 + 8'(i), 25'(i + 1)});
    vecs.push_back('{25'd3,        8'hB3, 25'd10});
    vecs.push_back('{25'h1FFFFFF,  8'h77, 25'd10});
    vecs.push_back('{25'h7F,       8'h11, 25'h80});

    // reset and idle
    repeat (3) begin
      step();
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_din", bus.mem_din, 0);
      chk("rst_wait", ioctl_wait, 0);
      chk("rst_rd_en", buff_rd_en, 0);
      chk("rst_din", buff_din, 0);
    end
    reset = 1'b0;
    step();
    chk("rd_en_after_reset", buff_rd_en, 1);
    chk("req_after_reset", bus.mem_req, 0);

    // download table
    set_dl(1'b1);
    step();
    chk("dl_rd_en_off", buff_rd_en, 0);
    foreach (vecs[i]) begin
      wait_wr_free();
      drive_wr(vecs[i].off, vecs[i].data);
      step();
      chk("dl_wait", ioctl_wait, 1);
      chk("dl_req_lag", bus.mem_req, 0);
      wait_req("dl_req");
      ea = vecs[i].off + BASE_V;
      chk("dl_we", bus.mem_we, 1);
      chk("dl_addr", bus.mem_addr, ea);
      chk("dl_din", bus.mem_din, vecs[i].data);
      repeat (3) begin
        step();
        chk("dl_rd_en_low", buff_rd_en, 0);
      end
      chk("dl_size", tape_size, vecs[i].exp_size);
    end
    set_dl(1'b0);
    step();
    chk("dl_end_rd_en", buff_rd_en, 1);

    // tape read
    ack_lat   = 3;
    buff_addr = 25'd5;
    buff_rd   = 1'b1;
    step();
    buff_rd = 1'b0;
    chk("rd_req", bus.mem_req, 1);
    chk("rd_we", bus.mem_we, 0);
    chk("rd_addr", bus.mem_addr, 25'd5 + BASE_V);
    chk("rd_en_held", buff_rd_en, 1);
    chk("rd_din_hold", buff_din, 8'h00);
    finish_read("rd", 8'hA5);

    // collision: pending write and read request together
    ack_lat = 2;
    drive_wr(25'h30, 8'h5C);
    step();
    chk("col_wait", ioctl_wait, 1);
    buff_addr = 25'h30;
    buff_rd   = 1'b1;
    step();
    chk("col_first_req", bus.mem_req, 1);
    chk("col_first_we", bus.mem_we, 1);
    chk("col_rd_en", buff_rd_en, 1);
    n = 0;
    while (!(bus.mem_req && !bus.mem_we) && n < 40) begin
      step();
      n++;
      chk("col_rd_en_hold", buff_rd_en, 1);
    end
    buff_rd = 1'b0;
    chk("col_read_issued", bus.mem_req && !bus.mem_we, 1);
    chk("col_rd_addr", bus.mem_addr, 25'h30 + BASE_V);
    finish_read("col", 8'h5C);

    // back-pressure and same-edge write strobe
    ack_en = 1'b0;
    set_dl(1'b1);
    step();
    chk("size_clear", tape_size, 0);
    drive_wr(25'd20, 8'h21);
    step();
    chk("bp_wait1", ioctl_wait, 1);
    step();
    chk("bp_req", bus.mem_req, 1);
    drive_wr(25'd50, 8'h22);
    step();
    chk("bp_wait2", ioctl_wait, 1);
    chk("bp_size", tape_size, 25'd21);
    step();
    ack_en = 1'b1;
    n = 0;
    while (!bus.mem_ack && n < 20) begin step(); n++; end
    chk("bp_ack_seen", bus.mem_ack, 1);
    drive_wr(25'd60, 8'h23);
    step();
    chk("same_edge_wait", ioctl_wait, 1);
    chk("same_edge_size", tape_size, 25'd61);
    wait_wr_free();
    step();
    set_dl(1'b0);
    step();
    chk("bp_end_rd_en", buff_rd_en, 1);

    // reset in the middle of a read, then a stale ack
    ack_en    = 1'b0;
    buff_addr = 25'd7;
    buff_rd   = 1'b1;
    step();
    buff_rd = 1'b0;
    chk("mr_req", bus.mem_req, 1);
    chk("mr_we", bus.mem_we, 0);
    step();
    reset  = 1'b1;
    size_m = '0;
    step();
    chk("mr_req_drop", bus.mem_req, 0);
    chk("mr_din_clr", buff_din, 0);
    chk("mr_rd_en", buff_rd_en, 0);
    chk("mr_wait", ioctl_wait, 0);
    reset     = 1'b0;
    stale_ack = 1'b1;
    step();
    chk("mr_rd_en_up", buff_rd_en, 1);
    step();
    chk("mr_stale_din", buff_din, 0);
    chk("mr_stale_req", bus.mem_req, 0);
    ack_en = 1'b1;

    // randomized mix against the shadow memory and size model
    for (int it = 0; it < 150; it++) begin
      ack_lat = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0: begin
          if (!ioctl_wait) drive_wr(25'($urandom_range(0, 63)), 8'($urandom));
          step();
        end
        1: begin
          ra        = 25'($urandom_range(0, 63));
          buff_addr = ra;
          buff_rd   = 1'b1;
          wait_read_issue("rnd_issue");
          buff_rd = 1'b0;
          ea = ra + BASE_V;
          chk("rnd_rd_addr", bus.mem_addr, ea);
          finish_read("rnd", shadow[8'(ra)]);
        end
        default: step();
      endcase
    end
    wait_wr_free();
    repeat (4) step();
    chk("exp_wr_empty", exp_wr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
